// File: rtl/axi_slave_ni_reorder_ctrl.sv
// rtl/axi_slave_ni_reorder_ctrl.sv - per-(direction, TID) ordering guard for the Slave NI request path
module axi_slave_ni_reorder_ctrl #(
   parameter int  TIDS_M      = 16,
   parameter int  EXT_SLAVES  = 2,
   parameter int  MAX_PENDING = 4,
   localparam int TID_W       = (TIDS_M > 1) ? $clog2(TIDS_M) : 1,
   localparam int DST_W       = (EXT_SLAVES > 1) ? $clog2(EXT_SLAVES) : 1,
   localparam int CNT_W       = $clog2(MAX_PENDING + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  reorder_req,
   input  logic [1:0]            reorder_req_op,
   input  logic [TID_W-1:0]      reorder_req_tid,
   input  logic [EXT_SLAVES-1:0] reorder_req_dst_out,
   output logic [DST_W-1:0]      reorder_req_dst_in,
   output logic                  reorder_qualify_now,
   input  logic                  resp_done,
   input  logic                  resp_done_op,
   input  logic [TID_W-1:0]      resp_done_tid,
   output logic [1:0]            err_flags
);

   // Index 0 of the first dimension is the write table, index 1 the read table.
   logic [CNT_W-1:0] cnt_q [2][TIDS_M];
   logic [CNT_W-1:0] cnt_d [2][TIDS_M];
   logic [DST_W-1:0] dst_q [2][TIDS_M];
   logic [DST_W-1:0] dst_d [2][TIDS_M];
   logic [1:0]       err_q, err_d;

   logic [DST_W-1:0] enc;
   logic             op_legal;
   logic             hit;
   logic             req_dir;
   logic [CNT_W-1:0] sel_cnt;
   logic [DST_W-1:0] sel_dst;
   logic [CNT_W-1:0] done_cnt;
   logic             done_dec;
   logic             qualify;

   // Lowest set index wins; an empty vector encodes to 0.
   always_comb begin
      enc = '0;
      for (int i = EXT_SLAVES - 1; i >= 0; i--) begin
         if (reorder_req_dst_out[i]) enc = DST_W'(i);
      end
   end

   assign op_legal = (reorder_req_op == 2'b01) || (reorder_req_op == 2'b10);
   assign hit      = |reorder_req_dst_out;
   assign req_dir  = reorder_req_op[1];
   assign sel_cnt  = cnt_q[req_dir][reorder_req_tid];
   assign sel_dst  = dst_q[req_dir][reorder_req_tid];
   assign done_cnt = cnt_q[resp_done_op][resp_done_tid];
   assign done_dec = resp_done && (done_cnt != '0);

   assign qualify = !rst && reorder_req && op_legal && hit &&
                    ((sel_cnt == '0) ||
                     ((sel_dst == enc) && (sel_cnt < CNT_W'(MAX_PENDING))));

   assign err_d = err_q | {resp_done && (done_cnt == '0),
                           reorder_req && !(op_legal && hit)};

   // Decrement is applied first so a same-entry qualify nets to no change.
   always_comb begin
      cnt_d = cnt_q;
      dst_d = dst_q;
      if (done_dec) begin
         cnt_d[resp_done_op][resp_done_tid] = done_cnt - CNT_W'(1);
      end
      if (qualify) begin
         cnt_d[req_dir][reorder_req_tid] = cnt_d[req_dir][reorder_req_tid] + CNT_W'(1);
         dst_d[req_dir][reorder_req_tid] = enc;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int d = 0; d < 2; d++) begin
            for (int t = 0; t < TIDS_M; t++) begin
               cnt_q[d][t] <= '0;
               dst_q[d][t] <= '0;
            end
         end
         err_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         dst_q <= dst_d;
         err_q <= err_d;
      end
   end

   assign reorder_req_dst_in  = enc;
   assign reorder_qualify_now = qualify;
   assign err_flags           = err_q;

endmodule

// File: doc/axi_slave_ni_reorder_ctrl.md
# axi_slave_ni_reorder_ctrl

Per-TID ordering guard for the Slave NI request path. It answers each request-path ordering query (`reorder_req`) in the same cycle, using per-(direction, TID) outstanding counters and the last destination slave. A new AXI transaction may enter the NoC only if it cannot overtake an earlier same-ID transaction headed to a different slave. Outstanding entries are released by completion pulses from the Slave NI response path.

## Interface
Parameters:
- `TIDS_M`, default 16: number of AXI transaction IDs. `TID_W = log2c_1if1(TIDS_M)`.
- `EXT_SLAVES`, default 2: number of external slaves. `DST_W = log2c_1if1(EXT_SLAVES)`.
- `MAX_PENDING`, default 4 (≥1): maximum outstanding transactions per (direction, TID). `CNT_W = $clog2(MAX_PENDING+1)`.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `reorder_req`, in, 1: request path asks to qualify the current address beat. Held until qualified.
- `reorder_req_op`, in, 2: one-hot direction. 2'b01 = write, 2'b10 = read.
- `reorder_req_tid`, in, TID_W: binary AxID.
- `reorder_req_dst_out`, in, EXT_SLAVES: slave hit vector from the address LUT.
- `reorder_req_dst_in`, out, DST_W: binary-encoded destination slave, returned to the packetizer.
- `reorder_qualify_now`, out, 1: the request may proceed this cycle.
- `resp_done`, in, 1: one response completion per cycle (B received, or RLAST beat received).
- `resp_done_op`, in, 1: 0 = write, 1 = read.
- `resp_done_tid`, in, TID_W: TID of the completed transaction.
- `err_flags`, out, 2: sticky errors. bit0 = unmapped/illegal request, bit1 = completion underflow.

## Operation
State:
- Two tables, WR and RD, each with TIDS_M entries.
- Each entry holds `cnt[CNT_W]` and `dst[DST_W]`.
- Reset value of every `cnt` and `dst` is 0.

Destination encode:
- `reorder_req_dst_in` is a priority encode of `reorder_req_dst_out`; the lowest set index wins.
- An all-zero vector encodes to 0.

Qualify rule (combinational):
- `reorder_qualify_now = reorder_req & op_legal & hit & (cnt==0 | (dst==enc & cnt<MAX_PENDING))`.
- The entry is selected by op and tid.
- `op_legal` is true only for `reorder_req_op` equal to 01 or 10.
- `hit` is `|reorder_req_dst_out`.

Qualify update (at the edge after `reorder_qualify_now`=1):
- Selected `cnt` += 1.
- Selected `dst` <= encoded destination.

Completion update:
- On `resp_done` with entry `cnt>0`: `cnt` -= 1. `dst` is retained.
- On `resp_done` with `cnt==0`: state unchanged; set `err_flags[1]`.

Simultaneous qualify and completion:
- Same entry: `cnt` is unchanged and `dst` is written. The dst values are equal anyway, since the qualify required matching dst or cnt==0.
- Different entries: both updates apply.

Illegal request:
- Condition: `reorder_req` with an illegal op or `hit`=0.
- Response: no qualify, no state change, set `err_flags[0]`.
- The request path stalls. This condition is a system configuration bug.

Other rules:
- WR and RD tables are fully independent (AXI ordering is per direction).
- The block never drops a completion and never decrements below 0.
- `cnt` saturates logically at MAX_PENDING: requests are blocked there, so no increment beyond it occurs.

## Timing
- Qualify latency is 0 cycles: combinational from table state and request inputs.
- `dst_in` latency is 0 cycles: combinational from `reorder_req_dst_out`.
- A completion in cycle N affects qualification from cycle N+1. There is no same-cycle bypass from `resp_done` to `reorder_qualify_now`.
- A qualification in cycle N is visible to a following same-TID request from cycle N+1.

During `rst`:
- All tables cleared.
- `err_flags` = 0.
- `reorder_qualify_now` forced to 0.
- `reorder_req_dst_in` keeps following its input.

Reset asserted mid-operation:
- All outstanding state is discarded.
- The first post-reset request to any TID qualifies if it is mapped.

## Test plan
1. Reset, then write req tid=3, dst_out=2'b10 -> `qualify_now`=1, `dst_in`=1 same cycle. Next cycle WR[3].cnt=1.
2. WR[3] holds cnt=1, dst=1; a write req tid=3 to dst_out=2'b01 -> qualify_now=0, held.
   - Then `resp_done`(op=0, tid=3) in cycle N -> qualify_now still 0 in N, =1 in N+1.
3. MAX_PENDING=4: issue 4 reads tid=0 to slave 0 -> all qualify. The 5th is blocked. One completion -> the 5th qualifies the next cycle; cnt returns to 4.
4. Read req tid=5 qualifying in the same cycle as `resp_done`(op=1, tid=5), with RD[5].cnt=2 -> cnt stays 2. A write to tid=5 on another slave qualifies independently.
5. Error cases:
   - Request with dst_out=0 -> qualify_now=0, err_flags=2'b01.
   - `resp_done` to an idle entry -> err_flags=2'b11, cnt remains 0.
6. Random bench against a reference model, 10k cycles, TIDS_M=16, EXT_SLAVES=4 -> no same-TID/same-direction request qualifies to a different slave while cnt>0; counters match the model every cycle.
